// File: rtl/hazard_ctrl.sv
// Purpose : hazard/stall sequencer for the 5-stage MIPS pipeline (load-use, branch, jump, dmem wait).
// Latency : zero; enables, flush and bubble are Mealy outputs of the current state and inputs.
// Backpr. : a dmem wait freezes PC and all pipeline registers until mem_ready; a load-use stalls PC and IF/ID.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IFID_UsesRt,
  input  logic        Jump,
  input  logic        BranchTaken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PC_enable,
  output logic        IFID_enable,
  output logic        IFID_flush,
  output logic        IDEX_enable,
  output logic        IDEX_bubble,
  output logic        EXMEM_enable,
  output logic        MEMWB_enable,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        mem_error
);

  typedef enum logic [1:0] {RUN, LOADUSE, FLUSH, MEMWAIT} state_t;

  localparam logic [7:0] LP_TIMEOUT = MEM_TIMEOUT[7:0];

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;
  logic        r_mem_error;

  logic        w_in_memwait;
  logic        w_loaduse;
  logic        w_freeze;
  logic        w_release;
  logic        w_flush_evt;
  logic [7:0]  w_wait_nxt;
  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_ifid_flush;
  logic        w_idex_en;
  logic        w_idex_bubble;
  logic        w_exmem_en;
  logic        w_memwb_en;

  // Hazard detection: a load in EX whose rt feeds the ID instruction; $zero never hazards.
  always_comb begin
    w_in_memwait = (r_state == MEMWAIT);
    w_loaduse    = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    // Once in MEMWAIT only mem_ready releases the freeze.
    w_freeze     = w_in_memwait ? !mem_ready : (mem_req && !mem_ready);
    w_release    = w_in_memwait && mem_ready;
    // Counts frozen cycles of the current wait, first frozen cycle = 1; saturates so it cannot re-arm.
    w_wait_nxt   = w_in_memwait ? ((r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1) : 8'd1;
  end

  // Priority resolution of the pipeline controls and next state; everything is zero while in reset.
  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b1;
    w_idex_bubble = 1'b0;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_flush_evt   = 1'b0;
    w_next_state  = RUN;
    if (w_freeze) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_memwb_en   = 1'b0;
      w_next_state = MEMWAIT;
    end else if (w_release) begin
      w_next_state = RUN;
    end else if (BranchTaken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_flush_evt   = 1'b1;
      w_next_state  = FLUSH;
    end else if (w_loaduse) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_bubble = 1'b1;
      w_next_state  = LOADUSE;
    end else if (Jump) begin
      w_ifid_flush = 1'b1;
      w_flush_evt  = 1'b1;
      w_next_state = FLUSH;
    end
    if (!reset) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_en     = 1'b0;
      w_idex_bubble = 1'b0;
      w_exmem_en    = 1'b0;
      w_memwb_en    = 1'b0;
      w_flush_evt   = 1'b0;
    end
  end

  // State, wait counter, saturating debug counters and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_wait_cnt     <= 8'd0;
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
      r_mem_error    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_freeze) begin
        r_wait_cnt <= w_wait_nxt;
        if (w_wait_nxt == LP_TIMEOUT) r_mem_error <= 1'b1;
      end
      if (!w_pc_en && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_flush_evt && (r_flush_count != 16'hFFFF)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign PC_enable    = w_pc_en;
  assign IFID_enable  = w_ifid_en;
  assign IFID_flush   = w_ifid_flush;
  assign IDEX_enable  = w_idex_en;
  assign IDEX_bubble  = w_idex_bubble;
  assign EXMEM_enable = w_exmem_en;
  assign MEMWB_enable = w_memwb_en;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign mem_error    = r_mem_error;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC through their enable, flush and bubble inputs. It resolves four cases: load-use data hazards, taken branches, jumps, and data-memory wait states. It also keeps saturating stall and flush counters and a sticky memory-timeout flag for debug.

## Interface
- MEM_TIMEOUT, 16: cycles in MEMWAIT before mem_error sets; legal range 1–255.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- IDEX_MemRead  in  1  MemRead_Out of the ID/EX register (a load is in EX).
- IDEX_Rt  in  5  destination rt of the instruction in EX.
- IFID_Rs  in  5  rs field of the instruction in ID.
- IFID_Rt  in  5  rt field of the instruction in ID.
- IFID_UsesRt  in  1  the ID instruction reads rt (R-type, store, branch).
- Jump  in  1  jump/jal decoded in ID.
- BranchTaken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes its access this cycle.
- PC_enable  out  1  PC may update.
- IFID_enable  out  1  IF/ID may load.
- IFID_flush  out  1  IF/ID loads a NOP.
- IDEX_enable  out  1  ID/EX may load.
- IDEX_bubble  out  1  ID/EX loads all-zero control.
- EXMEM_enable  out  1  EX/MEM may load.
- MEMWB_enable  out  1  MEM/WB may load.
- stall_cycles  out  16  count of cycles with PC_enable=0; saturates at 0xFFFF.
- flush_count  out  16  count of branch/jump flushes; saturates at 0xFFFF.
- mem_error  out  1  sticky: a memory wait reached MEM_TIMEOUT.

## Operation
- There are four states: RUN, LOADUSE, FLUSH and MEMWAIT. All outputs are combinational from the current state and inputs (Mealy).
- Conditions are checked in priority order, first match wins.
- **1. Memory wait:** mem_req=1 and mem_ready=0.
  - All five enables are 0; flush and bubble are 0.
  - Next state is MEMWAIT.
  - Other hazards are ignored that cycle; their inputs are held by the frozen pipeline.
- **2. Branch taken:** BranchTaken=1.
  - PC_enable=1, IFID_flush=1, IDEX_bubble=1; all other enables are 1.
  - flush_count increments. Next state is FLUSH.
- **3. Load-use:** IDEX_MemRead=1, IDEX_Rt≠0, and either IDEX_Rt==IFID_Rs or (IFID_UsesRt=1 and IDEX_Rt==IFID_Rt).
  - PC_enable=0, IFID_enable=0, IDEX_bubble=1.
  - IDEX_enable, EXMEM_enable and MEMWB_enable are 1.
  - Next state is LOADUSE.
- **4. Jump:** Jump=1.
  - IFID_flush=1; all enables are 1. flush_count increments.
  - Next state is FLUSH.
- **5. Otherwise:** all enables are 1, flush and bubble are 0. Next state is RUN.
- **State behaviour:**
  - LOADUSE and FLUSH last exactly one cycle. Their outputs are evaluated with the same priority list.
  - MEMWAIT stays until mem_ready=1. On that cycle all enables are 1, then the state returns to priority evaluation.
- **Wait counter (8-bit):**
  - Clears on entry to MEMWAIT and increments each MEMWAIT cycle.
  - When it equals MEM_TIMEOUT, mem_error sets. mem_error stays set until reset.
  - The pipeline stays frozen until mem_ready; timeout does not abort the access.
- **Counters:**
  - stall_cycles increments on every post-reset cycle with PC_enable=0.
  - Both counters saturate and do not wrap.
- **Reset (reset=0, at any time, including mid-MEMWAIT):**
  - State is RUN; the wait counter, stall_cycles, flush_count and mem_error are 0.
  - All enables, IFID_flush and IDEX_bubble are 0.
  - Outputs return to RUN behaviour combinationally after reset deasserts.

## Timing
- Hazard detection and the response happen in the same cycle (zero latency). Pipeline registers sample enables, flush and bubble on the next posedge.
- A load-use hazard costs exactly 1 bubble.
- A taken branch costs 2 flushed slots (IF/ID and ID/EX).
- A jump costs 1 flushed slot.
- A memory wait of N cycles with mem_ready low costs N frozen cycles.
- Counter updates and mem_error set on the posedge that ends the qualifying cycle.
- mem_error rises on the posedge after the MEM_TIMEOUT-th MEMWAIT cycle.
- Jump and BranchTaken in the same cycle: the branch wins, and flush_count increments once.
- Load-use with IDEX_Rt=0: no stall.

## Test plan
- **Load-use:** lw $t0 in EX with IDEX_Rt=8, IFID_Rs=8.
  - Required: PC_enable=0, IFID_enable=0, IDEX_bubble=1 for one cycle; stall_cycles=1; the next cycle is RUN with all enables 1.
- **Branch taken:** BranchTaken=1 for one cycle.
  - Required: IFID_flush=1, IDEX_bubble=1, PC_enable=1; flush_count=1; the following cycle shows no flush.
- **Simultaneous events:**
  - BranchTaken=1 together with a load-use match and Jump=1: branch response only, no stall, flush_count +1.
  - Jump=1 alone: IFID_flush=1, IDEX_bubble=0.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Required: all enables 0 for 3 cycles, all enables 1 on the 4th; stall_cycles=3; mem_error=0.
- **Timeout:** MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles.
  - Required: mem_error=1 after the 4th wait cycle and still 1 after mem_ready returns.
- **Reset and saturation:**
  - Assert reset mid-MEMWAIT: all outputs 0 immediately (asynchronous); after release, RUN with counters 0.
  - Force 70000 stall cycles: stall_cycles holds 0xFFFF.
